b_lut_infer: RTL and testbench
==============================

# b_lut_infer

Inverse of the ternary bitwise `bop` operation. Given operand triples (`rd`, `rs1`, `rs2`) and the `result` a `bop` produced, the block recovers the 8-bit LUT that `bop` applied. It scans the 32 bit positions over several cycles and can accumulate evidence across several requests. It sits beside the xcrypto bitwise unit as a verification/analysis helper: it checks whether an observed transformation is a valid `bop` and reports which LUT entries were exercised.

## Interface
- `BPC`, default 4: bit positions processed per cycle. Legal values are 1, 2, 4, 8, 16 and 32. Scan length is `N = 32/BPC`.
- `g_clk` in 1: clock; all state updates on the rising edge.
- `g_resetn` in 1: reset, synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request; equals `state==IDLE`.
- `req_clear` in 1: at acceptance, clear `lut`, `known` and `conflict` before scanning. If 0, the scan accumulates onto the existing state.
- `req_rd`, `req_rs1`, `req_rs2` in 32 each: operands.
- `req_result` in 32: observed `bop` output.
- `rsp_valid` out 1: inference result available.
- `rsp_ready` in 1: consumer accepts the response.
- `lut` out 8: inferred LUT. Entry k is meaningful only if `known[k]` is set.
- `known` out 8: LUT entries observed at least once.
- `conflict` out 1: sticky; the same index was observed with both 0 and 1.
- `lut_full` out 1: `&known`.

## Operation
- Index for bit i: `idx = {rd[i], rs2[i], rs1[i]}` (`rd` is the MSB). This is the same indexing `bop` uses.
- Update rule for bit i:
  - If `known[idx]` is set and `lut[idx] != result[i]`, set `conflict`. `lut` is unchanged, so the first write wins.
  - Otherwise set `lut[idx] = result[i]` and `known[idx] = 1`.
- Within one cycle, the `BPC` bits are applied in ascending bit order, chained. A later bit sees updates made by earlier bits in the same slice.
- States: IDLE, SCAN, DONE.
  - IDLE:
    - `req_ready=1`.
    - On `req_valid`, capture the operands and `result` into registers and set `cnt=0`.
    - If `req_clear`, zero `lut`, `known` and `conflict`.
    - Go to SCAN.
  - SCAN:
    - Process slice `cnt` (bits `cnt*BPC` to `cnt*BPC+BPC-1`) and increment `cnt`.
    - After slice N-1, go to DONE.
    - Inputs are ignored during SCAN.
  - DONE:
    - `rsp_valid=1`.
    - On `rsp_ready`, go to IDLE. `lut`, `known` and `conflict` are retained.
- Outputs are registered and stable whenever `rsp_valid=1`.
- Reset (at any point, including mid-SCAN): state IDLE, `cnt=0`, `lut=0`, `known=0`, `conflict=0`, `rsp_valid=0`, `req_ready=1`, `lut_full=0`. Captured operands are discarded.

## Timing
- Acceptance at edge E0 (`req_valid & req_ready`).
- Slices are processed at edges E1 through EN.
- `rsp_valid` is high from the cycle after EN until the `rsp_ready` handshake.
- Latency from acceptance to `rsp_valid` is N+1 cycles. With `BPC=4` that is 9 cycles.
- Minimum request-to-request spacing is N+2 cycles: the response handshake returns to IDLE, and IDLE takes one cycle.
- No combinational path from `req_*` to `rsp_*`.
- `req_ready` depends only on state.

## Configuration
- `B_LUT_INFER_EARLY_EXIT_EN` defined:
  - At the edge where `conflict` becomes, or already is, 1 during SCAN, go to DONE instead of continuing.
  - An accumulating request that starts with `conflict=1` reaches DONE after one SCAN cycle.
  - `lut` and `known` reflect only the slices processed up to that point.
- Undefined: all N slices are always processed, and latency is fixed at N+1.

## Structure
- Shared package/header `b_lut_infer_pkg`: state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), `XLEN=32`, `LUT_W=8`, and the index-bit ordering constants.
- Sub-module `b_lut_infer_slice`: combinational. Inputs are `BPC` bits of each operand plus the current `lut`, `known` and `conflict`. Outputs are the next `lut`, `known` and `conflict`, using the chained ascending update.
- The top level holds the FSM, counter, operand registers and handshakes.

## Test plan
- **XOR3 recovery:** clear=1, rs1=0x55555555, rs2=0x33333333, rd=0x0F0F0F0F, result=0x69696969. Expect lut=0x96, known=0xFF, conflict=0, lut_full=1, `rsp_valid` at N+1 cycles after acceptance.
- **Conflict:** same operands, result=0x69696968. Expect conflict=1 and lut[7]=0 (first write wins). With `B_LUT_INFER_EARLY_EXIT_EN` and `BPC=1`, DONE is reached after 9 SCAN cycles (conflict at bit 8) instead of 32.
- **Accumulation:**
  - clear=1, all operands 0, result=0. Expect known=0x01, lut=0x00.
  - Then clear=0, all operands 0xFFFFFFFF, result=0xFFFFFFFF. Expect known=0x81, lut=0x80, lut_full=0.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles in DONE. Expect `rsp_valid` held, outputs stable, `req_ready=0`, and a new `req_valid` ignored until the handshake completes.
- **Mid-scan reset:** assert `g_resetn=0` for one cycle during SCAN. Next cycle: IDLE, req_ready=1, lut=0, known=0, conflict=0, rsp_valid=0.
- **BPC sweep:** repeat the XOR3 case for `BPC` in {1, 8, 32}. Expect identical results with latencies of 33, 5 and 2 cycles.

Source files
------------

// File: rtl/b_lut_infer_pkg.sv
// b_lut_infer_pkg: state encoding, widths and LUT index bit ordering shared by the bop LUT inference block
package b_lut_infer_pkg;
  localparam int XLEN = 32;
  localparam int LUT_W = 8;
  localparam int IDX_RS1 = 0;
  localparam int IDX_RS2 = 1;
  localparam int IDX_RD = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [2:0] lut_idx(input logic rd, input logic rs2, input logic rs1);
    logic [2:0] v;
    v = '0;
    v[IDX_RD] = rd;
    v[IDX_RS2] = rs2;
    v[IDX_RS1] = rs1;
    return v;
  endfunction
endpackage

// File: rtl/b_lut_infer_slice.sv
// b_lut_infer_slice: applies BPC bit observations to the LUT state in ascending order, first write wins
module b_lut_infer_slice
  import b_lut_infer_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic [BPC-1:0]   i_rd,
  input  logic [BPC-1:0]   i_rs1,
  input  logic [BPC-1:0]   i_rs2,
  input  logic [BPC-1:0]   i_res,
  input  logic [LUT_W-1:0] i_lut,
  input  logic [LUT_W-1:0] i_known,
  input  logic             i_conflict,
  output logic [LUT_W-1:0] o_lut,
  output logic [LUT_W-1:0] o_known,
  output logic             o_conflict
);
  logic [2:0] w_idx;
  logic       w_hit;
  always_comb begin
    o_lut = i_lut;
    o_known = i_known;
    o_conflict = i_conflict;
    w_idx = '0;
    w_hit = 1'b0;
    for (int b = 0; b < BPC; b++) begin
      w_idx = lut_idx(i_rd[b], i_rs2[b], i_rs1[b]);
      w_hit = o_known[w_idx] && (o_lut[w_idx] != i_res[b]);
      o_conflict = o_conflict | w_hit;
      o_lut[w_idx] = w_hit ? o_lut[w_idx] : i_res[b];
      o_known[w_idx] = 1'b1;
    end
  end
endmodule

// File: rtl/b_lut_infer.sv
// b_lut_infer: recovers the bop LUT from operand/result triples; B_LUT_INFER_EARLY_EXIT_EN ends a scan on conflict
module b_lut_infer
  import b_lut_infer_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_clear,
  input  logic [XLEN-1:0]  req_rd,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [XLEN-1:0]  req_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [LUT_W-1:0] lut,
  output logic [LUT_W-1:0] known,
  output logic             conflict,
  output logic             lut_full
);
  localparam int N = XLEN / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [XLEN-1:0]  r_rd, r_rs1, r_rs2, r_res;
  logic [LUT_W-1:0] r_lut, r_known, w_lut, w_known;
  logic             r_conflict, w_conflict, w_accept, w_last, w_stop;
  // operands shift down each slice so the active bits always sit at the bottom
  b_lut_infer_slice #(.BPC(BPC)) u_slice (
    .i_rd      (r_rd[BPC-1:0]),
    .i_rs1     (r_rs1[BPC-1:0]),
    .i_rs2     (r_rs2[BPC-1:0]),
    .i_res     (r_res[BPC-1:0]),
    .i_lut     (r_lut),
    .i_known   (r_known),
    .i_conflict(r_conflict),
    .o_lut     (w_lut),
    .o_known   (w_known),
    .o_conflict(w_conflict)
  );
  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_last = r_cnt == CW'(N - 1);
`ifdef B_LUT_INFER_EARLY_EXIT_EN
  assign w_stop = w_last || w_conflict;
`else
  assign w_stop = w_last;
`endif
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE) ? (req_valid ? SCAN : IDLE) :
             (r_state == SCAN) ? (w_stop ? DONE : SCAN) :
             (r_state == DONE) ? (rsp_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge g_clk) begin
    if (!g_resetn) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_cnt <= '0;
      r_rd <= '0;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_res <= '0;
      r_lut <= '0;
      r_known <= '0;
      r_conflict <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_rd <= req_rd;
      r_rs1 <= req_rs1;
      r_rs2 <= req_rs2;
      r_res <= req_result;
      if (req_clear) begin
        r_lut <= '0;
        r_known <= '0;
        r_conflict <= 1'b0;
      end
    end else if (r_state == SCAN) begin
      r_cnt <= r_cnt + 1'b1;
      r_rd <= r_rd >> BPC;
      r_rs1 <= r_rs1 >> BPC;
      r_rs2 <= r_rs2 >> BPC;
      r_res <= r_res >> BPC;
      r_lut <= w_lut;
      r_known <= w_known;
      r_conflict <= w_conflict;
    end
  end
  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == DONE;
  assign lut = r_lut;
  assign known = r_known;
  assign conflict = r_conflict;
  assign lut_full = &r_known;
endmodule

// File: tb/tb_b_lut_infer.sv
// tb_b_lut_infer: directed checks of b_lut_infer with BPC 4 (main), 1, 8 and 32 instances on shared inputs
module tb_b_lut_infer;
  localparam int BPCS [4] = '{4, 1, 8, 32};
`ifdef B_LUT_INFER_EARLY_EXIT_EN
  localparam int CONF_LAT4 = 4;
  localparam int CONF_LAT1 = 10;
`else
  localparam int CONF_LAT4 = 9;
  localparam int CONF_LAT1 = 33;
`endif
  logic g_clk = 1'b0, g_resetn = 1'b0, req_valid = 1'b0, req_clear = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_rd = '0, req_rs1 = '0, req_rs2 = '0, req_result = '0;
  logic req_ready [4], rsp_valid [4], conflict [4], lut_full [4];
  logic [7:0] lut [4], known [4];
  int lat [4];
  int errors = 0, checks = 0;
  always #5 g_clk = ~g_clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    b_lut_infer #(.BPC(BPCS[g])) u_dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .req_valid(req_valid), .req_ready(req_ready[g]),
      .req_clear(req_clear), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_result(req_result), .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready),
      .lut(lut[g]), .known(known[g]), .conflict(conflict[g]), .lut_full(lut_full[g])
    );
  end
  task automatic run_req(input logic clr, input logic [31:0] rd, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] res);
    req_clear = clr; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_result = res;
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) lat[k] = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge g_clk); #1;
      req_valid = 1'b0;
      for (int k = 0; k < 4; k++) if (lat[k] == 0 && rsp_valid[k]) lat[k] = c;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
    end
  endtask
  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge g_clk);
    #1 g_resetn = 1'b1;
    checks += 6;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready[0]); end
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid[0]); end
    if (lut[0] !== 8'h00) begin errors++; $display("FAIL reset_lut got %h want 00", lut[0]); end
    if (known[0] !== 8'h00) begin errors++; $display("FAIL reset_known got %h want 00", known[0]); end
    if (conflict[0] !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b want 0", conflict[0]); end
    if (lut_full[0] !== 1'b0) begin errors++; $display("FAIL reset_lut_full got %b want 0", lut_full[0]); end
  endtask
  task automatic test_xor3();
    run_req(1'b1, 32'h0F0F0F0F, 32'h55555555, 32'h33333333, 32'h69696969);
    checks += 5;
    if (lat[0] != 9) begin errors++; $display("FAIL xor3_latency got %0d want 9", lat[0]); end
    if (lut[0] !== 8'h96) begin errors++; $display("FAIL xor3_lut got %h want 96", lut[0]); end
    if (known[0] !== 8'hFF) begin errors++; $display("FAIL xor3_known got %h want ff", known[0]); end
    if (conflict[0] !== 1'b0) begin errors++; $display("FAIL xor3_conflict got %b want 0", conflict[0]); end
    if (lut_full[0] !== 1'b1) begin errors++; $display("FAIL xor3_lut_full got %b want 1", lut_full[0]); end
    ack();
  endtask
  task automatic test_conflict();
    run_req(1'b1, 32'h0F0F0F0F, 32'h55555555, 32'h33333333, 32'h69696968);
    checks += 5;
    if (conflict[0] !== 1'b1) begin errors++; $display("FAIL conflict_flag got %b want 1", conflict[0]); end
    if (lut[0] !== 8'h16) begin errors++; $display("FAIL conflict_lut got %h want 16", lut[0]); end
    if (conflict[1] !== 1'b1) begin errors++; $display("FAIL conflict_flag_bpc1 got %b want 1", conflict[1]); end
    if (lat[0] != CONF_LAT4) begin errors++; $display("FAIL conflict_latency_bpc4 got %0d want %0d", lat[0], CONF_LAT4); end
    if (lat[1] != CONF_LAT1) begin errors++; $display("FAIL conflict_latency_bpc1 got %0d want %0d", lat[1], CONF_LAT1); end
    ack();
  endtask
  task automatic test_accumulate();
    run_req(1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    checks += 2;
    if (known[0] !== 8'h01) begin errors++; $display("FAIL acc0_known got %h want 01", known[0]); end
    if (lut[0] !== 8'h00) begin errors++; $display("FAIL acc0_lut got %h want 00", lut[0]); end
    ack();
    run_req(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    checks += 4;
    if (known[0] !== 8'h81) begin errors++; $display("FAIL acc1_known got %h want 81", known[0]); end
    if (lut[0] !== 8'h80) begin errors++; $display("FAIL acc1_lut got %h want 80", lut[0]); end
    if (lut_full[0] !== 1'b0) begin errors++; $display("FAIL acc1_lut_full got %b want 0", lut_full[0]); end
    if (conflict[0] !== 1'b0) begin errors++; $display("FAIL acc1_conflict got %b want 0", conflict[0]); end
    ack();
  endtask
  task automatic test_backpressure();
    run_req(1'b1, 32'h0F0F0F0F, 32'h55555555, 32'h33333333, 32'h69696969);
    req_clear = 1'b1; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_result = '0;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge g_clk); #1;
      checks += 4;
      if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid cycle %0d got %b want 1", c, rsp_valid[0]); end
      if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_req_ready cycle %0d got %b want 0", c, req_ready[0]); end
      if (lut[0] !== 8'h96) begin errors++; $display("FAIL bp_lut cycle %0d got %h want 96", c, lut[0]); end
      if (known[0] !== 8'hFF) begin errors++; $display("FAIL bp_known cycle %0d got %h want ff", c, known[0]); end
    end
    req_valid = 1'b0;
    ack();
    checks += 3;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_after_req_ready got %b want 1", req_ready[0]); end
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_after_rsp_valid got %b want 0", rsp_valid[0]); end
    if (lut[0] !== 8'h96) begin errors++; $display("FAIL bp_after_lut got %h want 96", lut[0]); end
  endtask
  task automatic test_midscan_reset();
    req_clear = 1'b0; req_rd = 32'hFFFFFFFF; req_rs1 = 32'h0; req_rs2 = 32'h0; req_result = 32'hFFFFFFFF;
    req_valid = 1'b1;
    @(posedge g_clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    checks += 1;
    if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL mid_in_scan got req_ready %b want 0", req_ready[0]); end
    g_resetn = 1'b0;
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    checks += 6;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL mid_req_ready got %b want 1", req_ready[0]); end
    if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid[0]); end
    if (lut[0] !== 8'h00) begin errors++; $display("FAIL mid_lut got %h want 00", lut[0]); end
    if (known[0] !== 8'h00) begin errors++; $display("FAIL mid_known got %h want 00", known[0]); end
    if (conflict[0] !== 1'b0) begin errors++; $display("FAIL mid_conflict got %b want 0", conflict[0]); end
    if (lut_full[0] !== 1'b0) begin errors++; $display("FAIL mid_lut_full got %b want 0", lut_full[0]); end
  endtask
  task automatic test_bpc_sweep();
    int exp_lat [4];
    exp_lat = '{9, 33, 5, 2};
    run_req(1'b1, 32'h0F0F0F0F, 32'h55555555, 32'h33333333, 32'h69696969);
    for (int k = 1; k < 4; k++) begin
      checks += 3;
      if (lat[k] != exp_lat[k]) begin errors++; $display("FAIL sweep_latency bpc=%0d got %0d want %0d", BPCS[k], lat[k], exp_lat[k]); end
      if (lut[k] !== 8'h96) begin errors++; $display("FAIL sweep_lut bpc=%0d got %h want 96", BPCS[k], lut[k]); end
      if (known[k] !== 8'hFF) begin errors++; $display("FAIL sweep_known bpc=%0d got %h want ff", BPCS[k], known[k]); end
    end
    ack();
  endtask
  initial begin
    test_reset();
    test_xor3();
    test_conflict();
    test_accumulate();
    test_backpressure();
    test_midscan_reset();
    test_bpc_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
